// File: rtl/axi_stride_reader.sv
// rtl/axi_stride_reader.sv - strided AXI read-burst issuer with response checking
//
// Issues cfg_reqCnt read bursts at cfg_base + n*cfg_stride and checks the
// returning R beats for burst length, ID and (optionally) data content.
//
// Ports:
//   clk, resetN                     clock, asynchronous active-low reset
//   en                              gates new AR issue only
//   start                           one-cycle pulse, samples cfg_* and starts a run
//   cfg_base/stride/reqCnt/len/id   run configuration
//   m_ar_*                          AR initiator channel
//   m_r_*                           R channel (m_r_ready never back-pressures)
//   busy, done, errorCode, rspCnt   status
//
// Optional feature: define STRIDE_READER_DATA_CHECK_EN to check every beat's
// data against the low bits of its byte address (errorCode 4).
module axi_stride_reader #(
    parameter int ADDR_BITS            = 32,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int LOG_MAX_OUTSTANDING  = 2
) (
    input  logic                                  clk,
    input  logic                                  resetN,
    input  logic                                  en,
    input  logic                                  start,
    input  logic [ADDR_BITS-1:0]                  cfg_base,
    input  logic [ADDR_BITS-1:0]                  cfg_stride,
    input  logic [15:0]                           cfg_reqCnt,
    input  logic [BURST_LEN_WIDTH-1:0]            cfg_len,
    input  logic [TID_WIDTH-1:0]                  cfg_id,
    output logic                                  m_ar_valid,
    input  logic                                  m_ar_ready,
    output logic [ADDR_BITS-1:0]                  m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
    output logic [TID_WIDTH-1:0]                  m_ar_id,
    input  logic                                  m_r_valid,
    output logic                                  m_r_ready,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
    input  logic                                  m_r_last,
    input  logic [TID_WIDTH-1:0]                  m_r_id,
    output logic                                  busy,
    output logic                                  done,
    output logic [2:0]                            errorCode,
    output logic [15:0]                           rspCnt
);

    localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int OW = LOG_MAX_OUTSTANDING + 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(1 << LOG_MAX_OUTSTANDING);
    localparam logic [OW-1:0] OUT_ONE = OW'(1);
    localparam logic [BURST_LEN_WIDTH-1:0] BEAT_ONE = BURST_LEN_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       ar_valid_q, ar_valid_d;
    logic [ADDR_BITS-1:0]       ar_addr_q, ar_addr_d;
    logic [ADDR_BITS-1:0]       stride_q, stride_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
    logic [TID_WIDTH-1:0]       id_q, id_d;
    logic [15:0]                req_cnt_q, req_cnt_d;
    logic [15:0]                issued_q, issued_d;
    logic [OW-1:0]              out_q, out_d;
    logic [BURST_LEN_WIDTH-1:0] beat_q, beat_d;
    logic [2:0]                 err_q, err_d;
    logic [15:0]                rsp_cnt_q, rsp_cnt_d;

    logic       ar_hs, r_hs, r_end, final_beat, start_ok;
    logic [2:0] err_new;

`ifdef STRIDE_READER_DATA_CHECK_EN
    // Base address of the burst currently returning on R.
    logic [ADDR_BITS-1:0]  rsp_addr_q, rsp_addr_d;
    logic [ADDR_BITS-1:0]  beat_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    assign beat_addr = rsp_addr_q + (ADDR_BITS'(beat_q) << LOG_BLOCK_DATA_BYTES);
    assign exp_data  = DATA_WIDTH'(beat_addr);
`else
    logic data_unused;
    assign data_unused = ^m_r_data;
`endif

    assign m_r_ready  = resetN;
    assign m_ar_valid = ar_valid_q;
    assign m_ar_addr  = ar_addr_q;
    assign m_ar_len   = len_q;
    assign m_ar_id    = id_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign errorCode  = err_q;
    assign rspCnt     = rsp_cnt_q;

    always_comb begin
        state_d    = state_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        stride_d   = stride_q;
        len_d      = len_q;
        id_d       = id_q;
        req_cnt_d  = req_cnt_q;
        out_d      = out_q;
        beat_d     = beat_q;
        err_d      = err_q;
        rsp_cnt_d  = rsp_cnt_q;
        err_new    = 3'd0;
`ifdef STRIDE_READER_DATA_CHECK_EN
        rsp_addr_d = rsp_addr_q;
`endif
        ar_hs      = ar_valid_q & m_ar_ready;
        r_hs       = m_r_valid & m_r_ready;
        r_end      = r_hs & m_r_last;
        final_beat = (beat_q == len_q);
        start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        issued_d   = ar_hs ? issued_q + 16'd1 : issued_q;

        // A stray last with nothing outstanding is flagged, not counted below zero.
        if (ar_hs && !(r_end && out_q != '0))
            out_d = out_q + OUT_ONE;
        else if (!ar_hs && r_end && out_q != '0)
            out_d = out_q - OUT_ONE;

        if (r_hs) begin
            if (final_beat && !m_r_last)
                err_new = 3'd1;
            else if (!final_beat && m_r_last)
                err_new = 3'd2;
            else if (m_r_id != id_q)
                err_new = 3'd3;
`ifdef STRIDE_READER_DATA_CHECK_EN
            else if (m_r_data != exp_data)
                err_new = 3'd4;
`endif
            else if (out_q == '0)
                err_new = 3'd5;
            beat_d = m_r_last ? '0 : beat_q + BEAT_ONE;
        end
        if (err_q == 3'd0)
            err_d = err_new;
        if (r_end) begin
            rsp_cnt_d = rsp_cnt_q + 16'd1;
`ifdef STRIDE_READER_DATA_CHECK_EN
            rsp_addr_d = rsp_addr_q + stride_q;
`endif
        end

        // ar_addr_q always holds the next address to issue, so a fresh AR
        // can be raised in the same cycle the previous one handshakes.
        if (ar_hs)
            ar_addr_d = ar_addr_q + stride_q;
        if (ar_valid_q && !ar_hs)
            ar_valid_d = 1'b1;
        else
            ar_valid_d = (state_q == S_RUN) && en && (issued_d < req_cnt_q) && (out_d < MAX_OUT);

        case (state_q)
            S_RUN:   if (issued_d == req_cnt_q) state_d = S_DRAIN;
            S_DRAIN: if (out_d == '0) state_d = S_DONE;
            default: state_d = state_q;
        endcase

        if (start_ok) begin
            state_d    = (cfg_reqCnt == 16'd0) ? S_DONE : S_RUN;
            stride_d   = cfg_stride;
            len_d      = cfg_len;
            id_d       = cfg_id;
            req_cnt_d  = cfg_reqCnt;
            issued_d   = 16'd0;
            ar_addr_d  = cfg_base;
            ar_valid_d = en && (cfg_reqCnt != 16'd0) && (out_d < MAX_OUT);
            beat_d     = '0;
            err_d      = 3'd0;
            rsp_cnt_d  = 16'd0;
`ifdef STRIDE_READER_DATA_CHECK_EN
            rsp_addr_d = cfg_base;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            id_q       <= '0;
            req_cnt_q  <= '0;
            issued_q   <= '0;
            out_q      <= '0;
            beat_q     <= '0;
            err_q      <= 3'd0;
            rsp_cnt_q  <= '0;
`ifdef STRIDE_READER_DATA_CHECK_EN
            rsp_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            id_q       <= id_d;
            req_cnt_q  <= req_cnt_d;
            issued_q   <= issued_d;
            out_q      <= out_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            rsp_cnt_q  <= rsp_cnt_d;
`ifdef STRIDE_READER_DATA_CHECK_EN
            rsp_addr_q <= rsp_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_stride_reader.sv
// tb/tb_axi_stride_reader.sv - scoreboard bench for axi_stride_reader
module tb_axi_stride_reader;

    localparam int AW = 32, LW = 8, IW = 8, LOGB = 0, LOGO = 2;
    localparam int DW = 8 << LOGB;
    localparam int MAXO = 1 << LOGO;

    logic clk = 1'b0;
    logic resetN, en, start;
    logic [AW-1:0] cfg_base, cfg_stride;
    logic [15:0]   cfg_reqCnt;
    logic [LW-1:0] cfg_len;
    logic [IW-1:0] cfg_id;
    logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
    logic [AW-1:0] m_ar_addr;
    logic [LW-1:0] m_ar_len;
    logic [IW-1:0] m_ar_id, m_r_id;
    logic [DW-1:0] m_r_data;
    logic busy, done;
    logic [2:0] errorCode;
    logic [15:0] rspCnt;

    always #5 clk = ~clk;

    axi_stride_reader #(
        .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
        .LOG_BLOCK_DATA_BYTES(LOGB), .LOG_MAX_OUTSTANDING(LOGO)
    ) dut (
        .clk(clk), .resetN(resetN), .en(en), .start(start),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_reqCnt(cfg_reqCnt),
        .cfg_len(cfg_len), .cfg_id(cfg_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
        .m_r_last(m_r_last), .m_r_id(m_r_id),
        .busy(busy), .done(done), .errorCode(errorCode), .rspCnt(rspCnt)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [IW-1:0] id;
    } ar_t;

    ar_t exp_ar[$];
    ar_t rsp_q[$];
    int  checks = 0, errors = 0;
    int  ar_hs_cnt = 0, model_out = 0, rsp_beat = 0;
    bit  auto_rsp = 1, rand_ready = 0, rand_en = 0, corrupt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: AR scoreboard, hold-stability and outstanding-limit checks.
    initial begin
        logic          prev_valid = 0, prev_hs = 0, hs;
        logic [AW-1:0] prev_addr = '0;
        ar_t           e;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                prev_valid = 0;
                prev_hs    = 0;
            end else begin
                if (prev_valid && !prev_hs) begin
                    chk("ar_hold_valid", m_ar_valid, 1);
                    chk("ar_hold_addr", m_ar_addr, prev_addr);
                end
                if (model_out >= MAXO)
                    chk("ar_valid_at_limit", m_ar_valid, 0);
                hs = m_ar_valid && m_ar_ready;
                if (hs) begin
                    ar_hs_cnt++;
                    model_out++;
                    if (exp_ar.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ar: actual addr=%0h required none", m_ar_addr);
                        e = '{m_ar_addr, m_ar_len, m_ar_id};
                    end else begin
                        e = exp_ar.pop_front();
                        chk("ar_addr", m_ar_addr, e.addr);
                        chk("ar_len", m_ar_len, e.len);
                        chk("ar_id", m_ar_id, e.id);
                    end
                    rsp_q.push_back(e);
                end
                if (m_r_valid && m_r_ready && m_r_last && model_out > 0)
                    model_out--;
                prev_valid = m_ar_valid;
                prev_addr  = m_ar_addr;
                prev_hs    = hs;
            end
        end
    end

    // Responder (memory returns the low address byte) plus random ready/en.
    initial begin
        ar_t           b;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        forever begin
            tick();
            if (auto_rsp) begin
                if (rsp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    b = rsp_q[0];
                    a = b.addr + AW'(rsp_beat * (1 << LOGB));
                    d = a[DW-1:0];
                    if (corrupt) begin
                        d = d ^ DW'(1);
                        corrupt = 0;
                    end
                    m_r_valid = 1;
                    m_r_data  = d;
                    m_r_id    = b.id;
                    m_r_last  = (rsp_beat == int'(b.len));
                    if (m_r_last) begin
                        void'(rsp_q.pop_front());
                        rsp_beat = 0;
                    end else begin
                        rsp_beat++;
                    end
                end else begin
                    m_r_valid = 0;
                    m_r_last  = 0;
                end
            end
            if (rand_ready) m_ar_ready = 1'($urandom_range(0, 1));
            if (rand_en)    en = 1'($urandom_range(0, 1));
        end
    end

    task automatic begin_run(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input int cnt, input logic [LW-1:0] len, input logic [IW-1:0] id);
        for (int n = 0; n < cnt; n++)
            exp_ar.push_back('{base + AW'(n) * stride, len, id});
        tick();
        cfg_base = base; cfg_stride = stride; cfg_reqCnt = 16'(cnt);
        cfg_len = len; cfg_id = id; start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
    endtask

    task automatic finish_run(input int cnt, input logic [2:0] exp_err);
        bit ok;
        wait_done(ok);
        chk("done_reached", ok, 1);
        chk("busy_after_done", busy, 0);
        chk("rspCnt", rspCnt, 16'(cnt));
        chk("errorCode", errorCode, exp_err);
        chk("all_ars_issued", exp_ar.size(), 0);
    endtask

    task automatic drive_beat(input logic last, input logic [IW-1:0] id);
        m_r_valid = 1; m_r_last = last; m_r_id = id; m_r_data = '0;
        tick();
        m_r_valid = 0; m_r_last = 0;
    endtask

    initial begin
        bit ok;
        int n0;
        logic [AW-1:0] s;
        resetN = 0; en = 1; start = 0; m_ar_ready = 1;
        m_r_valid = 0; m_r_last = 0; m_r_id = '0; m_r_data = '0;
        cfg_base = '0; cfg_stride = '0; cfg_reqCnt = '0; cfg_len = '0; cfg_id = '0;
        #2;
        chk("rst_ar_valid", m_ar_valid, 0);
        chk("rst_r_ready", m_r_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", errorCode, 0);
        chk("rst_rspCnt", rspCnt, 0);
        chk("rst_ar_addr", m_ar_addr, 0);
        #10 resetN = 1;
        #1 chk("r_ready_after_reset", m_r_ready, 1);

        begin_run(32'hbeef, 32'd1, 3, 8'd0, 8'h11);
        finish_run(3, 3'd0);
        begin_run(32'h1, 32'hFFFF_FFFF, 3, 8'd0, 8'h22);
        finish_run(3, 3'd0);

        rand_ready = 1; rand_en = 1;
        for (int r = 0; r < 6; r++) begin
            s = ($urandom_range(0, 1) == 1) ? AW'($urandom) : AW'(0) - AW'($urandom_range(1, 64));
            n0 = $urandom_range(1, 10);
            begin_run(AW'($urandom), s, n0, LW'($urandom_range(0, 3)), IW'($urandom_range(0, 255)));
            finish_run(n0, 3'd0);
        end
        rand_ready = 0; rand_en = 0;
        tick();
        m_ar_ready = 1; en = 1;

        n0 = ar_hs_cnt;
        begin_run(32'h500, 32'h4, 0, 8'd0, 8'h1);
        @(negedge clk);
        chk("zero_cnt_done", done, 1);
        chk("zero_cnt_no_ar", ar_hs_cnt - n0, 0);

        rand_ready = 1;
        begin_run(32'h7000, 32'h20, 6, 8'd1, 8'h33);
        repeat (2) tick();
        cfg_base = 32'hdead_0000; cfg_reqCnt = 16'd2; start = 1;
        tick();
        start = 0;
        chk("start_ignored_busy", busy, 1);
        finish_run(6, 3'd0);
        rand_ready = 0;
        tick();
        m_ar_ready = 1;

        auto_rsp = 0; m_r_valid = 0;
        n0 = ar_hs_cnt;
        begin_run(32'h9000, 32'h40, 8, 8'd1, 8'h44);
        repeat (30) @(negedge clk);
        chk("limit_ar_count", ar_hs_cnt - n0, MAXO);
        chk("limit_ar_valid_low", m_ar_valid, 0);
        auto_rsp = 1;
        finish_run(8, 3'd0);

        auto_rsp = 0; m_r_valid = 0;
        n0 = ar_hs_cnt;
        begin_run(32'h100, 32'h40, 2, 8'd1, 8'h5);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ar_hs_cnt - n0 == 2) ok = 1;
        end
        chk("err_test_ars", ok, 1);
        rsp_q.delete(); rsp_beat = 0;
        tick();
        drive_beat(1, 8'h5);
        chk("early_last_err", errorCode, 3'd2);
        drive_beat(0, 8'h9);
        chk("first_error_wins", errorCode, 3'd2);
        drive_beat(1, 8'h5);
        wait_done(ok);
        chk("err_run_done", ok, 1);
        chk("err_run_rspCnt", rspCnt, 2);
        auto_rsp = 1;
        begin_run(32'h300, 32'h8, 2, 8'd2, 8'h6);
        @(negedge clk);
        chk("err_cleared_by_start", errorCode, 3'd0);
        finish_run(2, 3'd0);

`ifdef STRIDE_READER_DATA_CHECK_EN
        begin_run(32'h10, 32'h4, 3, 8'd3, 8'h7);
        finish_run(3, 3'd0);
        corrupt = 1;
        begin_run(32'h10, 32'h4, 3, 8'd3, 8'h7);
        finish_run(3, 3'd4);
`endif

        m_ar_ready = 0;
        begin_run(32'h2000, 32'h10, 3, 8'd0, 8'h7);
        @(negedge clk);
        chk("stall_valid", m_ar_valid, 1);
        chk("stall_addr", m_ar_addr, 32'h2000);
        for (int i = 0; i < 5; i++) begin
            tick();
            en = ~en;
            @(negedge clk);
            chk("stall_valid_en", m_ar_valid, 1);
            chk("stall_addr_en", m_ar_addr, 32'h2000);
        end
        tick();
        en = 1; m_ar_ready = 1;
        tick();
        #2 resetN = 0;
        #1;
        chk("arst_ar_valid", m_ar_valid, 0);
        chk("arst_r_ready", m_r_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", errorCode, 0);
        chk("arst_rspCnt", rspCnt, 0);
        chk("arst_ar_addr", m_ar_addr, 0);
        chk("arst_ar_len", m_ar_len, 0);
        chk("arst_ar_id", m_ar_id, 0);
        exp_ar.delete(); rsp_q.delete(); rsp_beat = 0; model_out = 0;
        m_r_valid = 0; m_r_last = 0;
        repeat (2) @(negedge clk);
        #2 resetN = 1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset_busy", busy, 0);
        chk("idle_after_reset_done", done, 0);
        chk("idle_after_reset_valid", m_ar_valid, 0);

        begin_run(32'hFFFF_FFFE, 32'h1, 4, 8'd1, 8'h8);
        finish_run(4, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_stride_reader.md
AXI_STRIDE_READER -- requirements
Module: axi_stride_reader

Interface
REQ-001 Parameter ADDR_BITS, 32, width of AR address and stride.
REQ-002 Parameter BURST_LEN_WIDTH, 8, width of AR len (beats-1).
REQ-003 Parameter TID_WIDTH, 8, width of AR/R transaction ID.
REQ-004 Parameter LOG_BLOCK_DATA_BYTES, 0, log2 of bytes per beat; DATA_WIDTH = 8<<LOG_BLOCK_DATA_BYTES.
REQ-005 Parameter LOG_MAX_OUTSTANDING, 2, log2 of the outstanding-burst limit.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 resetN  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  issue enable; low blocks new AR issue only.
REQ-009 start  in  1  one-cycle pulse; samples cfg_* and begins a run.
REQ-010 cfg_base / cfg_stride  in  ADDR_BITS each  first address; signed two's-complement stride.
REQ-011 cfg_reqCnt  in  16  number of bursts; cfg_len in BURST_LEN_WIDTH; cfg_id in TID_WIDTH.
REQ-012 m_ar_valid/m_ar_addr/m_ar_len/m_ar_id  out  1/ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH  AR initiator channel; m_ar_ready in 1.
REQ-013 m_r_valid/m_r_data/m_r_last/m_r_id  in  1/DATA_WIDTH/1/TID_WIDTH  R channel; m_r_ready out 1.
REQ-014 busy, done  out  1 each; errorCode  out  3; rspCnt  out  16 completed bursts.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when cfg_reqCnt ARs issued; DRAIN->DONE when outstanding==0; DONE->RUN on start.
REQ-016 cfg_reqCnt==0 on start -> DONE next cycle, no AR issued.
REQ-017 start while busy (RUN/DRAIN) is ignored; busy high exactly in RUN/DRAIN; done high exactly in DONE.
REQ-018 AR n (n=0..reqCnt-1) addr = cfg_base + n*cfg_stride, modulo 2^ADDR_BITS (wraps silently); len=cfg_len, id=cfg_id.
REQ-019 m_ar_valid asserts in RUN when en=1 and outstanding < 2^LOG_MAX_OUTSTANDING; once high, valid/addr/len/id hold stable until m_ar_ready, regardless of en.
REQ-020 First AR valid earliest one cycle after start; back-to-back ARs allowed every cycle.
REQ-021 Outstanding counter +1 on AR handshake, -1 on R handshake with m_r_last; both same cycle -> unchanged.
REQ-022 m_r_ready is 1 whenever resetN=1 (never back-pressures).
REQ-023 Beat counter per burst; on the (cfg_len+1)th beat m_r_last must be 1, else errorCode=1; m_r_last=1 earlier -> errorCode=2.
REQ-024 m_r_id != cfg_id -> errorCode=3; R handshake with outstanding==0 -> errorCode=5.
REQ-025 errorCode sticky, first error wins, cleared only by start or reset; errors do not stop the FSM.
REQ-026 rspCnt increments on each R handshake with m_r_last; cleared on start.

Reset
REQ-027 resetN low asynchronously forces IDLE; m_ar_valid=0, m_r_ready=0, busy=0, done=0, errorCode=0, rspCnt=0, outstanding=0, m_ar_addr/len/id=0.
REQ-028 Reset mid-run abandons all outstanding bursts; after release the block sits in IDLE awaiting start.

Configuration
REQ-029 Macro STRIDE_READER_DATA_CHECK_EN defined: each beat's m_r_data SHALL equal low DATA_WIDTH bits of (cfg_base + k*cfg_stride + beat*(1<<LOG_BLOCK_DATA_BYTES)) for burst k, else errorCode=4.
REQ-030 Macro undefined: m_r_data ignored, no response-address tracking logic, errorCode 4 never produced.

Verification
REQ-031 base=0xbeef, stride=1, reqCnt=3, len=0, ready=1 -> AR addrs 0xbeef,0xbef0,0xbef1; done=1 after 3rd last; rspCnt=3, errorCode=0.
REQ-032 base=0x1, stride=0xFFFFFFFF, reqCnt=3 -> AR addrs 0x1, 0x0, 0xFFFFFFFF.
REQ-033 LOG_MAX_OUTSTANDING=2, m_r_valid held 0, reqCnt=8 -> exactly 4 AR handshakes, then m_ar_valid=0 until an R last returns.
REQ-034 len=1, responder sends last on beat 0 -> errorCode=2; a later wrong m_r_id does not overwrite it; next start clears to 0.
REQ-035 m_ar_ready=0 for 5 cycles with en toggled -> m_ar_valid/addr stable throughout; resetN pulsed low mid-run -> all outputs at reset values asynchronously.
REQ-036 With STRIDE_READER_DATA_CHECK_EN, DATA_WIDTH=8, base=0x10, memory holding addr low byte -> errorCode=0; one corrupted byte -> errorCode=4.
